// File: rtl/buf_stream_pkg.sv
// Shared defaults and FSM state type for the buffer stream controller.
package buf_stream_pkg;

  localparam int unsigned BUF_ADDR_W = 13;
  localparam int unsigned BUF_SRC_W  = 16;
  localparam int unsigned BUF_DST_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    SRC,
    DST,
    DRAIN
  } state_t;

endpackage

// File: rtl/rd_fifo2.sv
// Two-entry FIFO that catches result-buffer read data; push and pop may coincide when full.
module rd_fifo2 #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/buf_stream_ctrl.sv
// Streams inbound words into a source buffer and result-buffer words out to a stream.
// Optional m_last output is built when BUF_STREAM_LAST_EN is defined.
module buf_stream_ctrl
  import buf_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = BUF_ADDR_W,
  parameter int unsigned SRC_W  = BUF_SRC_W,
  parameter int unsigned DST_W  = BUF_DST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_src,
  input  logic              start_dst,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_cnt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [SRC_W-1:0]  s_data,
  output logic              src_v,
  output logic [ADDR_W-1:0] src_a,
  output logic [SRC_W-1:0]  src_d,
  output logic              dst_v,
  output logic [ADDR_W-1:0] dst_a,
  input  logic [DST_W-1:0]  dst_d,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DST_W-1:0]  m_data,
`ifdef BUF_STREAM_LAST_EN
  output logic              m_last,
`endif
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] dst_a_q;
  logic              inflight;
  logic              done_q;
  logic [1:0]        fifo_count;
  logic [DST_W-1:0]  fifo_head;
  logic              pop;
  logic              load;
  logic              beat;
  logic              issue;
  logic              finish;

  rd_fifo2 #(.W(DST_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (dst_d),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    beat       = 1'b0;
    issue      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start_src) begin
          next_state = SRC;
          load       = 1'b1;
        end else if (start_dst) begin
          next_state = DST;
          load       = 1'b1;
        end
      end
      SRC: begin
        if (s_valid) begin
          beat = 1'b1;
          if (rem == '0) begin
            next_state = IDLE;
            finish     = 1'b1;
          end
        end
      end
      DST: begin
        // A same-cycle pop frees a slot, so a full pipeline still issues every cycle.
        if ((({1'b0, fifo_count} + {2'b0, inflight}) < 3'd2) || pop) begin
          issue = 1'b1;
          if (rem == '0) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          next_state = IDLE;
          finish     = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      rem      <= '0;
      dst_a_q  <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= next_state;
      inflight <= issue;
      done_q   <= finish;
      if (load) begin
        addr <= cmd_base;
        rem  <= cmd_cnt;
      end else if (beat || issue) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - ADDR_W'(1);
      end
      if (issue) dst_a_q <= addr;
    end
  end

  assign s_ready = (state == SRC);
  assign src_v   = beat;
  assign src_a   = beat ? addr : '0;
  assign src_d   = beat ? s_data : '0;
  // Read address only moves on an issuing cycle so the bank select stays put between reads.
  assign dst_v   = issue;
  assign dst_a   = issue ? addr : dst_a_q;
  assign m_data  = m_valid ? fifo_head : '0;
  assign busy    = (state != IDLE);
  assign done    = done_q;

`ifdef BUF_STREAM_LAST_EN
  logic [ADDR_W-1:0] out_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_rem <= '0;
    end else if (load) begin
      out_rem <= cmd_cnt;
    end else if (pop) begin
      out_rem <= out_rem - ADDR_W'(1);
    end
  end

  assign m_last = m_valid && (out_rem == '0) && ((state == DST) || (state == DRAIN));
`endif

endmodule

// File: tb/tb_buf_stream_ctrl.sv
// Randomized self-checking bench for buf_stream_ctrl; result buffer word equals its address.
module tb_buf_stream_ctrl;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned SRC_W  = 16;
  localparam int unsigned DST_W  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_src;
  logic              start_dst;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_cnt;
  logic              s_valid;
  logic              s_ready;
  logic [SRC_W-1:0]  s_data;
  logic              src_v;
  logic [ADDR_W-1:0] src_a;
  logic [SRC_W-1:0]  src_d;
  logic              dst_v;
  logic [ADDR_W-1:0] dst_a;
  logic [DST_W-1:0]  dst_d;
  logic              m_valid;
  logic              m_ready;
  logic [DST_W-1:0]  m_data;
`ifdef BUF_STREAM_LAST_EN
  logic              m_last;
`endif
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  buf_stream_ctrl #(
    .ADDR_W (ADDR_W),
    .SRC_W  (SRC_W),
    .DST_W  (DST_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_src (start_src),
    .start_dst (start_dst),
    .cmd_base  (cmd_base),
    .cmd_cnt   (cmd_cnt),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .src_v     (src_v),
    .src_a     (src_a),
    .src_d     (src_d),
    .dst_v     (dst_v),
    .dst_a     (dst_a),
    .dst_d     (dst_d),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
`ifdef BUF_STREAM_LAST_EN
    .m_last    (m_last),
`endif
    .busy      (busy),
    .done      (done)
  );

  // Result buffer: registered read, junk on idle cycles.
  always @(posedge clk) dst_d <= dst_v ? DST_W'(dst_a) : DST_W'($urandom);

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({s_ready, src_v, dst_v, m_valid, busy, done} !== 6'b0)
      $display("FAIL reset_flags got s_ready=%b src_v=%b dst_v=%b m_valid=%b busy=%b done=%b want all 0",
               s_ready, src_v, dst_v, m_valid, busy, done);
    if ({s_ready, src_v, dst_v, m_valid, busy, done} !== 6'b0) miscompares++;
    vectors++;
    if (src_a !== '0 || src_d !== '0 || dst_a !== '0 || m_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got src_a=%h src_d=%h dst_a=%h m_data=%h want 0", src_a, src_d, dst_a, m_data);
    end
`ifdef BUF_STREAM_LAST_EN
    vectors++;
    if (m_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m_last got %b want 0", m_last);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: s_valid always 1, 1: alternating starting with 1, 2: random
  task automatic test_src(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt,
                          input int mode, input bit conflict);
    int k;
    bit ended;
    logic v;
    logic [ADDR_W-1:0] ea;
    logic [SRC_W-1:0] d;
    k = 0;
    ended = 1'b0;
    @(negedge clk);
    start_src = 1'b1; start_dst = conflict; cmd_base = base; cmd_cnt = cnt; s_valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL src_start_idle busy=%b want 0", busy);
    end
    for (int t = 1; t < 300; t++) begin
      @(negedge clk);
      start_src = 1'b0;
      start_dst = conflict && (k <= int'(cnt));
      cmd_base  = ADDR_W'($urandom);
      cmd_cnt   = ADDR_W'($urandom);
      v = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(t % 2) : logic'($urandom_range(0, 1));
      d = SRC_W'($urandom);
      s_valid = v; s_data = d;
      #1;
      ea = base + ADDR_W'(k);
      if (k <= int'(cnt)) begin
        vectors++;
        if (s_ready !== 1'b1 || src_v !== v || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL src_ctl t=%0d s_ready=%b src_v=%b busy=%b want 1 %b 1", t, s_ready, src_v, busy, v);
        end
        if (v) begin
          vectors++;
          if (src_a !== ea || src_d !== d) begin
            miscompares++;
            $display("FAIL src_write beat=%0d src_a=%h src_d=%h want %h %h", k, src_a, src_d, ea, d);
          end
          k++;
        end
        vectors++;
        if (done !== 1'b0 || dst_v !== 1'b0 || m_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL src_quiet t=%0d done=%b dst_v=%b m_valid=%b want 0", t, done, dst_v, m_valid);
        end
`ifdef BUF_STREAM_LAST_EN
        vectors++;
        if (m_last !== 1'b0) begin
          miscompares++;
          $display("FAIL src_m_last t=%0d got %b want 0", t, m_last);
        end
`endif
      end else begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0 || src_v !== 1'b0) begin
          miscompares++;
          $display("FAIL src_done t=%0d done=%b busy=%b s_ready=%b src_v=%b want 1 0 0 0",
                   t, done, busy, s_ready, src_v);
        end
        ended = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ended) begin
      miscompares++;
      $display("FAIL src_timeout beats=%0d want %0d", k, int'(cnt) + 1);
    end
    @(negedge clk);
    s_valid = 1'b0; start_dst = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || dst_v !== 1'b0) begin
      miscompares++;
      $display("FAIL src_after done=%b busy=%b dst_v=%b want 0 0 0", done, busy, dst_v);
    end
  endtask

  // mode 0: m_ready held 1, 1: random m_ready
  task automatic test_dst(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] cnt, input int mode);
    int issued, popped, occ, fin_t;
    bit ended;
    logic r;
    logic [ADDR_W-1:0] prev_a, ea;
    issued = 0; popped = 0; occ = 0; fin_t = -1; ended = 1'b0;
    @(negedge clk);
    start_dst = 1'b1; cmd_base = base; cmd_cnt = cnt; m_ready = (mode == 0);
    #1;
    prev_a = dst_a;
    for (int t = 1; t < 400; t++) begin
      @(negedge clk);
      start_dst = 1'b0;
      cmd_base  = ADDR_W'($urandom);
      cmd_cnt   = ADDR_W'($urandom);
      r = (mode == 0) ? 1'b1 : logic'($urandom_range(0, 1));
      m_ready = r;
      #1;
      if (fin_t >= 0) begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || dst_v !== 1'b0) begin
          miscompares++;
          $display("FAIL dst_done t=%0d done=%b busy=%b m_valid=%b dst_v=%b want 1 0 0 0",
                   t, done, busy, m_valid, dst_v);
        end
        ended = 1'b1;
        break;
      end
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL dst_busy t=%0d done=%b busy=%b want 0 1", t, done, busy);
      end
      if (!dst_v) begin
        vectors++;
        if (dst_a !== prev_a) begin
          miscompares++;
          $display("FAIL dst_a_hold t=%0d dst_a=%h want %h", t, dst_a, prev_a);
        end
      end else begin
        ea = base + ADDR_W'(issued);
        vectors++;
        if (issued > int'(cnt) || dst_a !== ea) begin
          miscompares++;
          $display("FAIL dst_read n=%0d dst_a=%h want %h limit %0d", issued, dst_a, ea, int'(cnt) + 1);
        end
        issued++;
      end
      prev_a = dst_a;
      if (mode == 0) begin
        vectors++;
        if (m_valid !== logic'(t >= 3 && t <= 3 + int'(cnt))) begin
          miscompares++;
          $display("FAIL dst_rate t=%0d m_valid=%b want %b", t, m_valid, (t >= 3 && t <= 3 + int'(cnt)));
        end
      end
`ifdef BUF_STREAM_LAST_EN
      vectors++;
      if (m_last !== logic'(m_valid && popped == int'(cnt))) begin
        miscompares++;
        $display("FAIL dst_m_last t=%0d m_last=%b want %b", t, m_last, (m_valid && popped == int'(cnt)));
      end
`endif
      if (m_valid && r) begin
        ea = base + ADDR_W'(popped);
        vectors++;
        if (popped > int'(cnt) || m_data !== DST_W'(ea)) begin
          miscompares++;
          $display("FAIL dst_beat n=%0d m_data=%h want %h", popped, m_data, DST_W'(ea));
        end
        popped++;
        if (popped == int'(cnt) + 1) fin_t = t;
      end
      occ = occ + int'(dst_v) - int'(m_valid && r);
      vectors++;
      if (occ > 2 || occ < 0) begin
        miscompares++;
        $display("FAIL dst_occupancy t=%0d got %0d want 0..2", t, occ);
      end
    end
    vectors++;
    if (!ended || issued != int'(cnt) + 1) begin
      miscompares++;
      $display("FAIL dst_end ended=%b reads=%0d beats=%0d want %0d", ended, issued, popped, int'(cnt) + 1);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dst();
    int popped;
    logic [ADDR_W-1:0] base;
    popped = 0;
    base = ADDR_W'($urandom);
    @(negedge clk);
    start_dst = 1'b1; cmd_base = base; cmd_cnt = 13'd15; m_ready = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start_dst = 1'b0;
      #1;
      if (m_valid) begin
        vectors++;
        if (m_data !== DST_W'(base + ADDR_W'(popped))) begin
          miscompares++;
          $display("FAIL rst_pre_beat n=%0d m_data=%h want %h", popped, m_data, DST_W'(base + ADDR_W'(popped)));
        end
        popped++;
      end
    end
    vectors++;
    if (popped != 3) begin
      miscompares++;
      $display("FAIL rst_pre_count got %0d want 3", popped);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; m_ready = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || dst_v !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid m_valid=%b busy=%b dst_v=%b done=%b want 0", m_valid, busy, dst_v, done);
    end
    test_dst(ADDR_W'($urandom), 13'd9, 1);
  endtask

  task automatic test_start_conflict();
    test_src(13'h0123, 13'd2, 0, 1'b1);
    test_src(ADDR_W'($urandom), 13'd4, 2, 1'b1);
  endtask

  task automatic test_random_mix();
    repeat (6) begin
      test_src(ADDR_W'($urandom), ADDR_W'($urandom_range(0, 12)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      test_dst(ADDR_W'($urandom), ADDR_W'($urandom_range(0, 20)), int'($urandom_range(0, 1)));
    end
    test_dst(13'h1FFC, 13'd7, 0);
    test_dst(13'h0FFD, 13'd5, 1);
  endtask

  initial begin
    reset = 1'b1; start_src = 1'b0; start_dst = 1'b0; cmd_base = '0; cmd_cnt = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_src(13'h0FFE, 13'd3, 0, 1'b0);
    test_src(13'h1FFF, 13'd1, 1, 1'b0);
    test_dst(13'h0010, 13'd7, 0);
    test_dst(13'h0010, 13'd7, 1);
    test_reset_mid_dst();
    test_start_conflict();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
